// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcode encodings, execution latencies and the
// dispatch FSM state encoding used by the scheduler and the functional unit.
package tomasulo_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;

    localparam int CNT_W = 2;

    localparam logic [CNT_W-1:0] LAT_ADD = 2'd1;
    localparam logic [CNT_W-1:0] LAT_SUB = 2'd1;
    localparam logic [CNT_W-1:0] LAT_MUL = 2'd2;
    localparam logic [CNT_W-1:0] LAT_DIV = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_RESULT = 2'd2
    } fu_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: op_is_legal = 1'b1;
            default:                        op_is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] op_latency(input logic [3:0] op);
        case (op)
            OP_ADD:  op_latency = LAT_ADD;
            OP_SUB:  op_latency = LAT_SUB;
            OP_MUL:  op_latency = LAT_MUL;
            OP_DIV:  op_latency = LAT_DIV;
            default: op_latency = '0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: grants the first requesting entry at or after the
// pointer, wrapping from NUM_RS-1 back to 0. Purely combinational.
module rr_arbiter #(
    parameter int NUM_RS = 4,
    parameter int PTR_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
    input  logic [NUM_RS-1:0] req,
    input  logic [PTR_W-1:0]  pointer,
    output logic [NUM_RS-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (!found && req[(int'(pointer) + k) % NUM_RS]) begin
                grant[(int'(pointer) + k) % NUM_RS] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_dispatch_scheduler.sv
// Dispatches ready reservation-station entries to a single functional unit,
// tracks its latency and holds the result until the common data bus takes it.
module rs_dispatch_scheduler
    import tomasulo_pkg::*;
#(
    parameter int NUM_RS = 4,
    parameter int TAG_W  = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_RS-1:0]       rs_req,
    input  logic [4*NUM_RS-1:0]     rs_op,
    input  logic [TAG_W*NUM_RS-1:0] rs_tag,
    output logic [NUM_RS-1:0]       rs_grant,
    output logic                    fu_start,
    output logic [3:0]              fu_op,
    output logic [TAG_W-1:0]        fu_tag,
    output logic                    cdb_req,
    input  logic                    cdb_ack,
    output logic                    busy,
    output logic                    err_illegal
);

    localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    fu_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  rr_ptr;

    logic [NUM_RS-1:0] legal;
    logic [NUM_RS-1:0] eligible;
    logic [NUM_RS-1:0] arb_grant;
    logic              can_dispatch;
    logic              dispatch;
    logic [3:0]        sel_op;
    logic [TAG_W-1:0]  sel_tag;
    logic [CNT_W-1:0]  sel_lat;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  next_ptr;

    always_comb begin
        legal = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            legal[i] = op_is_legal(rs_op[4*i +: 4]);
        end
    end

    assign eligible    = rs_req & legal;
    assign err_illegal = |(rs_req & ~legal);

    rr_arbiter #(
        .NUM_RS (NUM_RS),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .req     (eligible),
        .pointer (rr_ptr),
        .grant   (arb_grant)
    );

    // Gated by reset_n so nothing is granted while reset is held.
    assign can_dispatch = reset_n &&
                          ((state == ST_IDLE) || ((state == ST_RESULT) && cdb_ack));
    assign rs_grant = can_dispatch ? arb_grant : '0;
    assign dispatch = |rs_grant;
    assign fu_start = dispatch;

    always_comb begin
        sel_op    = '0;
        sel_tag   = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (rs_grant[i]) begin
                sel_op    = rs_op[4*i +: 4];
                sel_tag   = rs_tag[TAG_W*i +: TAG_W];
                grant_idx = PTR_W'(i);
            end
        end
    end

    assign sel_lat  = op_latency(sel_op);
    assign next_ptr = (grant_idx == PTR_W'(NUM_RS - 1)) ? '0 : grant_idx + 1'b1;

    // cnt holds the EXEC cycles still to run, so a latency-1 op lands in
    // RESULT on the cycle right after fu_start and cdb_req rises L cycles later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rr_ptr <= '0;
            fu_op  <= '0;
            fu_tag <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_RESULT: begin
                    if (dispatch) begin
                        fu_op  <= sel_op;
                        fu_tag <= sel_tag;
                        rr_ptr <= next_ptr;
                        cnt    <= sel_lat - 1'b1;
                        state  <= (sel_lat == CNT_W'(1)) ? ST_RESULT : ST_EXEC;
                    end else if ((state == ST_RESULT) && cdb_ack) begin
                        state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_RESULT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cdb_req = (state == ST_RESULT);
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_rs_dispatch_scheduler.sv
// Directed bench for rs_dispatch_scheduler: dispatch timing, latency,
// round-robin order, CDB stall, illegal opcodes and mid-operation reset.
module tb_rs_dispatch_scheduler;

    logic        clock;
    logic        reset_n;
    logic [3:0]  rs_req;
    logic [15:0] rs_op;
    logic [11:0] rs_tag;
    logic [3:0]  rs_grant;
    logic        fu_start;
    logic [3:0]  fu_op;
    logic [2:0]  fu_tag;
    logic        cdb_req;
    logic        cdb_ack;
    logic        busy;
    logic        err_illegal;

    int n_cmp;
    int n_bad;

    rs_dispatch_scheduler #(
        .NUM_RS (4),
        .TAG_W  (3)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rs_req      (rs_req),
        .rs_op       (rs_op),
        .rs_tag      (rs_tag),
        .rs_grant    (rs_grant),
        .fu_start    (fu_start),
        .fu_op       (fu_op),
        .fu_tag      (fu_tag),
        .cdb_req     (cdb_req),
        .cdb_ack     (cdb_ack),
        .busy        (busy),
        .err_illegal (err_illegal)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_entry(input int i, input logic [3:0] op, input logic [2:0] tag);
        rs_op[4*i +: 4]  = op;
        rs_tag[3*i +: 3] = tag;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_grant"},   32'(rs_grant), 32'h0);
        check_eq({pfx, "_start"},   32'(fu_start), 32'h0);
        check_eq({pfx, "_fu_op"},   32'(fu_op),    32'h0);
        check_eq({pfx, "_fu_tag"},  32'(fu_tag),   32'h0);
        check_eq({pfx, "_cdb_req"}, 32'(cdb_req),  32'h0);
        check_eq({pfx, "_busy"},    32'(busy),     32'h0);
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        clock   = 1'b0;
        reset_n = 1'b1;
        rs_req  = '0;
        rs_op   = '0;
        rs_tag  = '0;
        cdb_ack = 1'b0;
        n_cmp   = 0;
        n_bad   = 0;
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset: outputs zero, no grant even with legal requests present
        #2 reset_n = 1'b0;
        rs_req = 4'b1111;
        @(negedge clock);
        check_all_zero("rst");
        check_eq("rst_err", 32'(err_illegal), 32'h0);
        rs_req = '0;
        @(negedge clock);
        reset_n = 1'b1;
        cyc();

        // Single ADD, tag 5, on entry 0
        set_entry(0, 4'b0000, 3'd5);
        rs_req = 4'b0001;
        @(negedge clock);
        check_eq("add_grant", 32'(rs_grant), 32'h1);
        check_eq("add_start", 32'(fu_start), 32'h1);
        check_eq("add_busy_t0", 32'(busy), 32'h0);
        check_eq("add_cdb_t0", 32'(cdb_req), 32'h0);
        cyc();
        rs_req  = '0;
        cdb_ack = 1'b1;
        @(negedge clock);
        check_eq("add_cdb_t1", 32'(cdb_req), 32'h1);
        check_eq("add_tag", 32'(fu_tag), 32'h5);
        check_eq("add_op", 32'(fu_op), 32'h0);
        check_eq("add_busy_t1", 32'(busy), 32'h1);
        check_eq("add_grant_t1", 32'(rs_grant), 32'h0);
        check_eq("add_start_t1", 32'(fu_start), 32'h0);
        cyc();
        cdb_ack = 1'b0;
        @(negedge clock);
        check_eq("add_idle_t2", 32'(busy), 32'h0);
        check_eq("add_cdb_t2", 32'(cdb_req), 32'h0);
        cyc();

        // MUL on entry 2: cdb_req at T+2, not T+1; ack in EXEC ignored
        set_entry(2, 4'b0100, 3'd3);
        rs_req = 4'b0100;
        @(negedge clock);
        check_eq("mul_grant", 32'(rs_grant), 32'h4);
        cyc();
        rs_req  = '0;
        cdb_ack = 1'b1;
        @(negedge clock);
        check_eq("mul_cdb_t1", 32'(cdb_req), 32'h0);
        check_eq("mul_busy_t1", 32'(busy), 32'h1);
        cyc();
        @(negedge clock);
        check_eq("mul_cdb_t2", 32'(cdb_req), 32'h1);
        check_eq("mul_op", 32'(fu_op), 32'h4);
        check_eq("mul_tag", 32'(fu_tag), 32'h3);
        cyc();
        cdb_ack = 1'b0;
        @(negedge clock);
        check_eq("mul_idle", 32'(busy), 32'h0);
        cyc();

        // Reset again so the round-robin pointer restarts at entry 0
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        cyc();

        // Round-robin with all four requesting ADD and cdb_ack held high
        for (int i = 0; i < 4; i++) set_entry(i, 4'b0000, 3'(i));
        rs_req  = 4'b1111;
        cdb_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check_eq($sformatf("rr_grant%0d", k), 32'(rs_grant), 32'(rr_exp[k]));
            cyc();
        end
        rs_req = '0;
        @(negedge clock);
        check_eq("rr_drain_grant", 32'(rs_grant), 32'h0);
        check_eq("rr_drain_cdb", 32'(cdb_req), 32'h1);
        cyc();
        cdb_ack = 1'b0;
        @(negedge clock);
        check_eq("rr_idle", 32'(busy), 32'h0);
        cyc();

        // CDB stall: SUB on entry 1 waits 5 cycles, then back-to-back grant
        set_entry(0, 4'b0000, 3'd4);
        set_entry(1, 4'b0001, 3'd6);
        rs_req = 4'b0010;
        @(negedge clock);
        check_eq("stall_grant", 32'(rs_grant), 32'h2);
        cyc();
        rs_req = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check_eq($sformatf("stall_cdb%0d", k), 32'(cdb_req), 32'h1);
            check_eq($sformatf("stall_op%0d", k), 32'(fu_op), 32'h1);
            check_eq($sformatf("stall_tag%0d", k), 32'(fu_tag), 32'h6);
            check_eq($sformatf("stall_grant%0d", k), 32'(rs_grant), 32'h0);
            cyc();
        end
        cdb_ack = 1'b1;
        @(negedge clock);
        check_eq("b2b_grant", 32'(rs_grant), 32'h1);
        check_eq("b2b_start", 32'(fu_start), 32'h1);
        cyc();
        cdb_ack = 1'b0;
        rs_req  = '0;
        @(negedge clock);
        check_eq("b2b_cdb", 32'(cdb_req), 32'h1);
        check_eq("b2b_tag", 32'(fu_tag), 32'h4);
        cyc();
        cdb_ack = 1'b1;
        cyc();
        cdb_ack = 1'b0;
        @(negedge clock);
        check_eq("b2b_idle", 32'(busy), 32'h0);
        cyc();

        // Illegal opcode on entry 1 is skipped; DIV on entry 2 wins twice
        set_entry(1, 4'b0010, 3'd1);
        set_entry(2, 4'b0101, 3'd2);
        rs_req = 4'b0110;
        @(negedge clock);
        check_eq("ill_err", 32'(err_illegal), 32'h1);
        check_eq("ill_grant", 32'(rs_grant), 32'h4);
        cyc();
        @(negedge clock);
        check_eq("ill_exec_grant", 32'(rs_grant), 32'h0);
        check_eq("ill_exec_err", 32'(err_illegal), 32'h1);
        check_eq("ill_exec_cdb", 32'(cdb_req), 32'h0);
        cyc();
        cdb_ack = 1'b1;
        @(negedge clock);
        check_eq("ill_res_cdb", 32'(cdb_req), 32'h1);
        check_eq("ill_b2b_grant", 32'(rs_grant), 32'h4);
        cyc();
        rs_req  = '0;
        cdb_ack = 1'b0;
        @(negedge clock);
        check_eq("ill_err_clear", 32'(err_illegal), 32'h0);
        check_eq("ill_exec2_busy", 32'(busy), 32'h1);
        check_eq("ill_exec2_cdb", 32'(cdb_req), 32'h0);
        cyc();
        cdb_ack = 1'b1;
        @(negedge clock);
        check_eq("ill_res2_cdb", 32'(cdb_req), 32'h1);
        cyc();
        cdb_ack = 1'b0;
        @(negedge clock);
        check_eq("ill_idle", 32'(busy), 32'h0);
        cyc();

        // Reset in the middle of a DIV
        rs_req = 4'b0100;
        @(negedge clock);
        check_eq("rdiv_grant", 32'(rs_grant), 32'h4);
        cyc();
        rs_req = '0;
        @(negedge clock);
        check_eq("rdiv_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check_all_zero("rdiv");
        @(negedge clock);
        reset_n = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_eq($sformatf("rdiv_post_cdb%0d", k), 32'(cdb_req), 32'h0);
            check_eq($sformatf("rdiv_post_busy%0d", k), 32'(busy), 32'h0);
            cyc();
        end
        for (int i = 0; i < 4; i++) set_entry(i, 4'b0000, 3'(i));
        rs_req = 4'b1111;
        @(negedge clock);
        check_eq("rdiv_first_grant", 32'(rs_grant), 32'h1);
        cyc();
        rs_req  = '0;
        cdb_ack = 1'b1;
        cyc();
        cdb_ack = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
